// File: rtl/hx8k_demo.sv
// hx8k_demo: wakes the SPI flash, reads a NUL-terminated string and streams it
// over UART 8N1, mirroring the last sent byte on the LEDs; CR restarts.

module hx8k_spi #(
  parameter int HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       done_o,
  output logic [7:0] rdata_o
);
  localparam logic [7:0] DIVM = 8'(HALF - 1);

  logic       busy_q, sck_q, mosi_q, done_q;
  logic [7:0] div_q, sh_q;
  logic [2:0] bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= '0;
      sh_q   <= '0;
      bit_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        sck_q <= 1'b0;
        if (start_i) begin
          busy_q <= 1'b1;
          sh_q   <= data_i;
          mosi_q <= data_i[7];
          div_q  <= '0;
          bit_q  <= '0;
        end
      end else if (div_q == DIVM) begin
        div_q <= '0;
        sck_q <= ~sck_q;
        // rising edge samples MISO, falling edge presents the next MOSI bit
        if (!sck_q) begin
          sh_q <= {sh_q[6:0], miso_i};
        end else if (bit_q == 3'd7) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          bit_q  <= bit_q + 3'd1;
          mosi_q <= sh_q[7];
        end
      end else begin
        div_q <= div_q + 8'd1;
      end
    end
  end

  assign sck_o   = sck_q;
  assign mosi_o  = mosi_q;
  assign done_o  = done_q;
  assign rdata_o = sh_q;
endmodule

module hx8k_uart_tx #(
  parameter int DIV = 106
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);
  localparam logic [15:0] DIVM = 16'(DIV - 1);

  logic        busy_q;
  logic [15:0] div_q;
  logic [3:0]  bit_q;
  logic [9:0]  sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q <= 1'b1;
        sh_q   <= {1'b1, data_i, 1'b0};
        div_q  <= '0;
        bit_q  <= '0;
      end
    end else if (div_q == DIVM) begin
      div_q <= '0;
      sh_q  <= {1'b1, sh_q[9:1]};
      if (bit_q == 4'd9) busy_q <= 1'b0;
      else bit_q <= bit_q + 4'd1;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  assign tx_o   = busy_q ? sh_q[0] : 1'b1;
  assign busy_o = busy_q;
endmodule

module hx8k_uart_rx #(
  parameter int DIV = 106
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       vld_o,
  output logic [7:0] data_o
);
  localparam logic [15:0] DIVM  = 16'(DIV - 1);
  localparam logic [15:0] HALFM = 16'(DIV / 2 - 1);

  logic [2:0]  s_q;
  logic        act_q, vld_q;
  logic [15:0] cnt_q;
  logic [3:0]  bit_q;
  logic [7:0]  sh_q;
  logic        rx;

  assign rx = s_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '1;
      act_q <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      s_q   <= {s_q[1:0], rx_i};
      vld_q <= 1'b0;
      if (!act_q) begin
        if (s_q[2] && !rx) begin
          act_q <= 1'b1;
          cnt_q <= HALFM;
          bit_q <= '0;
        end
      end else if (cnt_q == '0) begin
        cnt_q <= DIVM;
        bit_q <= bit_q + 4'd1;
        if (bit_q == 4'd0) begin
          if (rx) act_q <= 1'b0;
        end else if (bit_q == 4'd9) begin
          act_q <= 1'b0;
          vld_q <= rx;
        end else begin
          sh_q <= {rx, sh_q[7:1]};
        end
      end else begin
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = sh_q;
endmodule

module hx8k_demo #(
  parameter int          UART_DIV   = 106,
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int          MAX_LEN    = 4096,
  parameter int          SPI_HALF   = 2,
  parameter int          WAKE_DELAY = 64
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [7:0] leds,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic       flash_csb,
  output logic       flash_clk,
  inout  wire        flash_io0,
  inout  wire        flash_io1,
  inout  wire        flash_io2,
  inout  wire        flash_io3
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);
  localparam logic [15:0] HOLDM = 16'(SPI_HALF - 1);
  localparam logic [15:0] GAPM  = 16'(4 * SPI_HALF - 1);
  localparam logic [15:0] WAITM = 16'(WAKE_DELAY - 1);

  localparam logic [2:0] S_WAKE  = 3'd0;
  localparam logic [2:0] S_TAIL  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CMD   = 3'd3;
  localparam logic [2:0] S_FETCH = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

  logic [2:0]    st_q, st_d, nxt_q, nxt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    leds_q, leds_d;
  logic          csb_q, csb_d, iss_q, iss_d, rst_q, rst_d;

  logic       spi_go, spi_done, mosi, tx_go, tx_busy, rx_vld, cr;
  logic [7:0] spi_tx, spi_rd, rx_dat, cmd_b;

  hx8k_spi #(.HALF(SPI_HALF)) u_spi (
    .clk(clk), .rst_n(resetn), .start_i(spi_go), .data_i(spi_tx),
    .miso_i(flash_io1), .sck_o(flash_clk), .mosi_o(mosi),
    .done_o(spi_done), .rdata_o(spi_rd)
  );

  hx8k_uart_tx #(.DIV(UART_DIV)) u_tx (
    .clk(clk), .rst_n(resetn), .start_i(tx_go), .data_i(spi_rd),
    .tx_o(ser_tx), .busy_o(tx_busy)
  );

  hx8k_uart_rx #(.DIV(UART_DIV)) u_rx (
    .clk(clk), .rst_n(resetn), .rx_i(ser_rx),
    .vld_o(rx_vld), .data_o(rx_dat)
  );

  assign flash_io0 = mosi;
  assign flash_io1 = 1'bz;
  assign flash_io2 = 1'b1;
  assign flash_io3 = 1'b1;
  assign flash_csb = csb_q;
  assign leds      = leds_q;
  assign cr        = rx_vld && (rx_dat == 8'h0D);

  always_comb begin
    cmd_b = 8'h03;
    unique case (1'b1)
      idx_q == 2'd0: cmd_b = 8'h03;
      idx_q == 2'd1: cmd_b = FLASH_ADDR[23:16];
      idx_q == 2'd2: cmd_b = FLASH_ADDR[15:8];
      idx_q == 2'd3: cmd_b = FLASH_ADDR[7:0];
    endcase
  end

  always_comb begin
    st_d   = st_q;
    nxt_d  = nxt_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    len_d  = len_q;
    leds_d = leds_q;
    csb_d  = csb_q;
    iss_d  = iss_q;
    rst_d  = rst_q;
    spi_go = 1'b0;
    spi_tx = 8'h00;
    tx_go  = 1'b0;
    unique case (st_q)
      S_WAKE: begin
        csb_d = 1'b0;
        if (!iss_q) begin
          spi_go = 1'b1;
          spi_tx = 8'hAB;
          iss_d  = 1'b1;
        end
        if (spi_done) begin
          iss_d = 1'b0;
          cnt_d = '0;
          nxt_d = S_WAIT;
          st_d  = S_TAIL;
        end
      end
      S_TAIL: begin
        // keep csb low one half period past the last SCK fall
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HOLDM) begin
          cnt_d = '0;
          csb_d = 1'b1;
          st_d  = nxt_q;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == WAITM) begin
          cnt_d = '0;
          st_d  = S_CMD;
        end
      end
      S_CMD: begin
        csb_d = 1'b0;
        if (!iss_q) begin
          spi_go = 1'b1;
          spi_tx = cmd_b;
          iss_d  = 1'b1;
        end
        if (spi_done) begin
          iss_d = 1'b0;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) st_d = S_FETCH;
        end
      end
      S_FETCH: begin
        csb_d = 1'b0;
        if (!iss_q) begin
          spi_go = 1'b1;
          iss_d  = 1'b1;
        end
        if (spi_done) begin
          iss_d = 1'b0;
          cnt_d = '0;
          if (rst_q) begin
            rst_d = 1'b0;
            nxt_d = S_GAP;
            st_d  = S_TAIL;
          end else if (spi_rd == 8'h00 || len_q == LMAX) begin
            nxt_d = S_DONE;
            st_d  = S_TAIL;
          end else begin
            tx_go  = 1'b1;
            leds_d = spi_rd;
            len_d  = len_q + 1'b1;
            st_d   = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          if (rst_q) begin
            rst_d = 1'b0;
            cnt_d = '0;
            nxt_d = S_GAP;
            st_d  = S_TAIL;
          end else begin
            st_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        csb_d = 1'b1;
        len_d = '0;
        if (rst_q) begin
          rst_d = 1'b0;
          cnt_d = '0;
          st_d  = S_GAP;
        end
      end
      S_GAP: begin
        csb_d = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAPM) begin
          cnt_d = '0;
          idx_d = '0;
          len_d = '0;
          st_d  = S_CMD;
        end
      end
      default: st_d = S_WAKE;
    endcase
    // restart requests only count once streaming has begun
    if (cr && (st_q == S_FETCH || st_q == S_SEND || st_q == S_DONE ||
               (st_q == S_TAIL && nxt_q != S_WAIT)))
      rst_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= S_WAKE;
      nxt_q  <= S_WAIT;
      cnt_q  <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      leds_q <= '0;
      csb_q  <= 1'b1;
      iss_q  <= 1'b0;
      rst_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      nxt_q  <= nxt_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      leds_q <= leds_d;
      csb_q  <= csb_d;
      iss_q  <= iss_d;
      rst_q  <= rst_d;
    end
  end
endmodule

// File: tb/tb_hx8k_demo.sv
// tb_hx8k_demo: directed bench with an SPI flash model and a per-cycle
// UART frame monitor on ser_tx.

module tb_hx8k_demo;
  localparam int DIV = 106;
  localparam int H   = 2;
  localparam int ML  = 16;
  localparam int FR  = 10 * DIV;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ser_rx = 1'b1;
  logic [7:0] leds;
  logic ser_tx, flash_csb, flash_clk;
  wire  flash_io0, flash_io1, flash_io2, flash_io3;
  logic miso = 1'b0;

  assign flash_io1 = miso;

  always #5 clk = ~clk;

  // MAX_LEN shrunk so the missing-NUL guard is reachable in a short run
  hx8k_demo #(
    .UART_DIV(DIV), .FLASH_ADDR(24'h100000), .MAX_LEN(ML),
    .SPI_HALF(H), .WAKE_DELAY(64)
  ) dut (
    .clk(clk), .resetn(resetn), .leds(leds), .ser_rx(ser_rx),
    .ser_tx(ser_tx), .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1),
    .flash_io2(flash_io2), .flash_io3(flash_io3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mem [0:63];
  logic [7:0]  fsh = '0;
  logic [23:0] faddr = '0;
  logic [7:0]  fb;
  int fcnt = 0, fk, foff;
  int csb_falls = 0, t_rise = 0, hi_len = 0;
  logic [7:0] cmdq[$];
  logic [7:0] txq[$];
  int bad_frames = 0;

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fcnt = 0;
      t_rise = cyc;
    end else begin
      fsh = {fsh[6:0], flash_io0};
      fcnt++;
      if (fcnt <= 32 && fcnt % 8 == 0) begin
        cmdq.push_back(fsh);
        if (fcnt > 8) faddr = {faddr[15:0], fsh};
      end
    end
  end

  always @(negedge flash_clk) begin
    if (flash_csb === 1'b0 && fcnt >= 32) begin
      fk = fcnt - 32;
      foff = int'(faddr) - 32'h100000 + fk / 8;
      fb = mem[foff & 63];
      miso = fb[7 - fk % 8];
    end
  end

  always @(negedge flash_csb) begin
    csb_falls++;
    hi_len = cyc - t_rise;
  end

  logic [FR-1:0] lv;
  logic ab;
  logic [7:0] md;
  int nb;
  always begin
    @(negedge ser_tx);
    #1;
    ab = !resetn;
    lv[0] = ser_tx;
    for (int c = 1; c < FR && !ab; c++) begin
      @(posedge clk);
      #1;
      if (!resetn) ab = 1'b1;
      else lv[c] = ser_tx;
    end
    if (!ab) begin
      nb = 0;
      for (int c = 0; c < FR; c++)
        if (lv[c] !== lv[(c / DIV) * DIV + DIV / 2]) nb++;
      if (lv[DIV / 2] !== 1'b0 || lv[9 * DIV + DIV / 2] !== 1'b1) nb++;
      for (int k = 0; k < 8; k++) md[k] = lv[(k + 1) * DIV + DIV / 2];
      if (nb != 0) bad_frames++;
      txq.push_back(md);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cq(input int i);
    return (i < cmdq.size()) ? 32'(cmdq[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] tq(input int i);
    return (i < txq.size()) ? 32'(txq[i]) : 32'hDEAD;
  endfunction

  task automatic wait_tx(input int n, input int budget, input string tag);
    int c = 0;
    while (txq.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk(tag, 32'(txq.size() >= n), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tx_low(input string tag);
    int c = 0;
    while (ser_tx === 1'b1 && c < 4000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(tag, 32'(ser_tx), 32'd0);
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
  endtask

  int n0, q0, na, c0;

  initial begin
    load_str("Hi");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ser_tx", 32'(ser_tx), 32'd1);
    chk("rst_csb", 32'(flash_csb), 32'd1);
    chk("rst_sck", 32'(flash_clk), 32'd0);
    chk("rst_io0", 32'(flash_io0), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_io23", 32'({flash_io2, flash_io3}), 32'd3);
    resetn = 1'b1;

    wait_tx(2, 6000, "hi_frames_timeout");
    repeat (200) @(posedge clk);
    #1;
    chk("hi_cmd_count", 32'(cmdq.size()), 32'd5);
    chk("hi_wake", cq(0), 32'hAB);
    chk("hi_read", cq(1), 32'h03);
    chk("hi_a2", cq(2), 32'h10);
    chk("hi_a1", cq(3), 32'h00);
    chk("hi_a0", cq(4), 32'h00);
    chk("hi_tx0", tq(0), 32'h48);
    chk("hi_tx1", tq(1), 32'h69);
    chk("hi_tx_count", 32'(txq.size()), 32'd2);
    chk("hi_leds", 32'(leds), 32'h69);
    chk("hi_csb_done", 32'(flash_csb), 32'd1);
    chk("hi_frame_timing", 32'(bad_frames), 32'd0);

    n0 = csb_falls;
    q0 = cmdq.size();
    send_rx(8'h41);
    repeat (500) @(posedge clk);
    #1;
    chk("rx41_no_csb", 32'(csb_falls), 32'(n0));
    chk("rx41_no_cmd", 32'(cmdq.size()), 32'(q0));

    cmdq.delete();
    txq.delete();
    send_rx(8'h0D);
    wait_tx(2, 6000, "cr_frames_timeout");
    repeat (200) @(posedge clk);
    #1;
    chk("cr_cmd_count", 32'(cmdq.size()), 32'd4);
    chk("cr_read_no_wake", cq(0), 32'h03);
    chk("cr_a2", cq(1), 32'h10);
    chk("cr_tx0", tq(0), 32'h48);
    chk("cr_tx1", tq(1), 32'h69);
    chk("cr_csb_done", 32'(flash_csb), 32'd1);

    for (int i = 0; i < 64; i++) mem[i] = 8'h41;
    txq.delete();
    send_rx(8'h0D);
    wait_tx(ML, 30000, "max_frames_timeout");
    repeat (3000) @(posedge clk);
    #1;
    na = 0;
    foreach (txq[i]) if (txq[i] == 8'h41) na++;
    chk("max_count", 32'(txq.size()), 32'(ML));
    chk("max_data", 32'(na), 32'(ML));
    chk("max_csb_done", 32'(flash_csb), 32'd1);

    load_str("Hello");
    cmdq.delete();
    txq.delete();
    send_rx(8'h0D);
    wait_tx(1, 4000, "hello_h_timeout");
    wait_tx_low("hello_e_start");
    send_rx(8'h0D);
    wait_tx(7, 12000, "hello_frames_timeout");
    repeat (300) @(posedge clk);
    #1;
    chk("hello_tx0", tq(0), 32'h48);
    chk("hello_tx1", tq(1), 32'h65);
    chk("hello_restart_h", tq(2), 32'h48);
    chk("hello_tx3", tq(3), 32'h65);
    chk("hello_tx6", tq(6), 32'h6F);
    chk("hello_tx_count", 32'(txq.size()), 32'd7);
    chk("hello_cmd_count", 32'(cmdq.size()), 32'd8);
    chk("hello_recmd", cq(4), 32'h03);
    chk("hello_gap", 32'(hi_len >= 4 * H), 32'd1);
    chk("hello_leds", 32'(leds), 32'h6F);

    send_rx(8'h0D);
    wait_tx_low("midframe_start");
    repeat (300) @(posedge clk);
    chk("midframe_leds_pre", 32'(leds), 32'h48);
    #3;
    resetn = 1'b0;
    #1;
    chk("midframe_ser_tx", 32'(ser_tx), 32'd1);
    chk("midframe_csb", 32'(flash_csb), 32'd1);
    chk("midframe_leds", 32'(leds), 32'd0);
    chk("midframe_sck", 32'(flash_clk), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    cmdq.delete();
    txq.delete();
    resetn = 1'b1;
    c0 = 0;
    while (cmdq.size() == 0 && c0 < 500) begin
      @(posedge clk);
      c0++;
    end
    chk("midframe_rewake", cq(0), 32'hAB);

    wait_tx(1, 4000, "midfetch_h_timeout");
    c0 = 0;
    while (flash_clk !== 1'b1 && c0 < 300) begin
      @(posedge clk);
      #1;
      c0++;
    end
    chk("midfetch_sck_pre", 32'(flash_clk), 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk("midfetch_sck", 32'(flash_clk), 32'd0);
    chk("midfetch_csb", 32'(flash_csb), 32'd1);
    chk("midfetch_leds", 32'(leds), 32'd0);
    chk("midfetch_ser_tx", 32'(ser_tx), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    cmdq.delete();
    resetn = 1'b1;
    c0 = 0;
    while (cmdq.size() == 0 && c0 < 500) begin
      @(posedge clk);
      c0++;
    end
    chk("midfetch_rewake", cq(0), 32'hAB);
    chk("all_frame_timing", 32'(bad_frames), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
